fetch_queue: RTL
================

# fetch_queue

Instruction-fetch front end with an in-order prefetch queue, sitting directly upstream of the IF/ID pipeline register. Issues sequential word fetches to an instruction memory with variable response latency, buffers returned instructions in a DEPTH-entry FIFO, and presents one PC/instruction pair per cycle to the decode stage. Honours the decode-side stall (`IF_ID_write`) and the MEM-stage branch redirect (`PCSrc`, `PC_Branch`), squashing queued and in-flight fetches on redirect.

## Interface
- `DEPTH`, 4, FIFO entries and maximum in-flight requests; power of two, 2..16
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-low; all state cleared while low
- `PCSrc` in 1, redirect request from branch control
- `PC_Branch` in 32, redirect target; valid when `PCSrc`=1
- `IF_ID_write` in 1, decode consumes the head entry this cycle when 1 and `IF_valid`=1
- `imem_req` out 1, fetch request valid
- `imem_addr` out 32, fetch address (word aligned)
- `imem_ready` in 1, memory accepts request this cycle
- `imem_rvalid` in 1, response valid (in order, ≥1 cycle after acceptance)
- `imem_rdata` in 32, instruction word
- `IF_valid` out 1, head entry valid
- `PC_IF` out 32, PC of head entry
- `INSTRUCTION_IF` out 32, head instruction; 32'h0000_0013 (NOP) when `IF_valid`=0

## Operation
- State: `fetch_pc`, FIFO (`occ` 0..DEPTH), `live` (accepted, not yet returned, to be kept), `discard` (accepted, to be dropped).
- Issue: `imem_req`=1 iff `PCSrc`=0 and `occ`+`live` < DEPTH and `live`+`discard` < DEPTH. `imem_addr`=`fetch_pc`. On `imem_req`&`imem_ready`: `fetch_pc` += 4, `live` += 1.
- Response: if `discard`>0, decrement `discard`, data dropped; else push {PC, `imem_rdata`} into FIFO, `live` -= 1. PC of each entry tracked by a parallel PC FIFO written at issue time.
- Pop: `IF_valid`&`IF_ID_write` advances head. `IF_ID_write`=0 holds outputs stable.
- Simultaneous push and pop at `occ`=DEPTH or `occ`=0 legal; credit rule guarantees no overflow. Push into empty FIFO visible next cycle (no bypass).
- Redirect (`PCSrc`=1 at edge): FIFO cleared, `fetch_pc`←`PC_Branch`, `discard`←`discard`+`live` minus any response arriving that cycle, `live`←0; concurrent pop and push ignored. `imem_req`=0 during redirect cycle.
- Address arithmetic mod 2^32; `fetch_pc` wraps 32'hFFFF_FFFC→0. `PC_Branch[1:0]` ignored (forced 0).
- Reset: `fetch_pc`=RESET_PC, `occ`=`live`=`discard`=0; outputs `imem_req`=0 while reset low, `IF_valid`=0, `PC_IF`=0, `INSTRUCTION_IF`=NOP. Responses arriving after reset deassert for pre-reset requests are a memory protocol violation (memory shares the reset).

## Timing
- First request combinationally asserted in the cycle after reset release.
- Fetch-to-output latency: accept at edge N, response at edge ≥N+1, `IF_valid` at cycle after response edge. Zero-wait memory sustains 1 instruction/cycle.
- Redirect: `PCSrc` high in cycle R → `imem_addr`=`PC_Branch` in R+1; earliest target `IF_valid` in R+3 with 1-cycle memory.
- Outputs are registered except `imem_req`/`imem_addr` (decode of `PCSrc` and counters).

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` (32, pushes into FIFO) and `perf_squashed` (32, entries flushed plus responses discarded), saturating, reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, 1-cycle memory, `IF_ID_write`=1 → addresses 0,4,8,… consecutive cycles; `IF_valid` from cycle 3, one instruction/cycle, PCs match.
- `IF_ID_write`=0 for 10 cycles → `occ` reaches 4, `imem_req`=0, head PC/instruction unchanged; release → 4 queued entries drained in order, no gap.
- `PCSrc`=1, `PC_Branch`=32'h0000_0100 with 3 in flight on 3-cycle memory → 3 responses dropped, next `PC_IF`=0x100, no stale PC ever valid.
- `PCSrc` coincident with response and pop at `occ`=1 → FIFO empty next cycle, `IF_valid`=0, `discard` correct.
- `RESET_PC`=32'hFFFF_FFF8 → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `reset` asserted mid-stream with `occ`=3 → immediately `IF_valid`=0, `imem_req`=0, `INSTRUCTION_IF`=0x00000013; with `FETCH_PERF_EN`, counters 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response bus between the fetch
// front end (master) and the instruction memory (slave).
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetch queue feeding the IF/ID register.
// Issues sequential word fetches, buffers returned words in a DEPTH-entry
// FIFO and squashes queued and in-flight fetches on a branch redirect.
// Optional macro FETCH_PERF_EN adds saturating fetch/squash counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCSrc,
    input  logic [31:0]         PC_Branch,
    input  logic                IF_ID_write,
    fetch_queue_if.master       mem,
    output logic                IF_valid,
    output logic [31:0]         PC_IF,
    output logic [31:0]         INSTRUCTION_IF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_squashed
`endif
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] occ;      // entries held in the FIFO
    logic [CW-1:0] live;     // accepted fetches whose data will be kept
    logic [CW-1:0] discard;  // accepted fetches whose data will be dropped
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] iss_ptr;

    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];

    logic          req;
    logic          issue;
    logic          push;
    logic          drop;
    logic          pop;

    // Only the low bits of the redirect target are ignored.
    logic [1:0]    unused_branch_bits;
    assign unused_branch_bits = PC_Branch[1:0];

    // The next fetch lands in the slot just past every live fetch, so its PC
    // sits beside the data slot its response will fill.
    assign iss_ptr = wr_ptr + live[PW-1:0];

    // Handshake decode: issue credit, response routing and head consumption.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        req   = 1'b0;
        issue = 1'b0;
        push  = 1'b0;
        drop  = 1'b0;
        pop   = 1'b0;
        if (reset && !PCSrc) begin
            req   = ((occ + live) < DEPTH_C) && ((live + discard) < DEPTH_C);
            issue = req && mem.imem_ready;
            drop  = mem.imem_rvalid && (discard != '0);
            push  = mem.imem_rvalid && (discard == '0);
            pop   = (occ != '0) && IF_ID_write;
        end
    end

    assign mem.imem_req  = req;
    assign mem.imem_addr = fetch_pc;

    // Fetch PC, occupancy/credit counters and FIFO pointers; redirect wins.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            fetch_pc <= RESET_PC;
            occ      <= '0;
            live     <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (PCSrc) begin
            fetch_pc <= {PC_Branch[31:2], 2'b00};
            occ      <= '0;
            live     <= '0;
            discard  <= discard + live - CW'(mem.imem_rvalid);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            occ     <= occ + CW'(push) - CW'(pop);
            live    <= live + CW'(issue) - CW'(push);
            discard <= discard - CW'(drop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // PC slot written at issue, instruction slot written at response.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; outputs are qualified by occ instead.
        if (issue) pc_mem[iss_ptr] <= fetch_pc;
        if (push)  ins_mem[wr_ptr] <= mem.imem_rdata;
    end

    assign IF_valid       = (occ != '0);
    assign PC_IF          = IF_valid ? pc_mem[rd_ptr]  : 32'h0;
    assign INSTRUCTION_IF = IF_valid ? ins_mem[rd_ptr] : NOP;

`ifdef FETCH_PERF_EN
    logic [CW-1:0] squash_inc;
    logic [32:0]   squash_sum;

    assign squash_inc = (PCSrc ? occ : '0)
                      + CW'(mem.imem_rvalid && ((discard != '0) || PCSrc));
    assign squash_sum = {1'b0, perf_squashed} + 33'(squash_inc);

    // Saturating counters: pushes into the FIFO, and flushed or dropped fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            perf_squashed <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end
`endif

endmodule
